// File: rtl/keypad_entry.sv
// keypad_entry: debounces press/release of decoded keypad digits and shifts
// each accepted digit into a DIGITS-deep BCD entry register.
module keypad_entry #(
    parameter int DEBOUNCE = 4,
    parameter int DIGITS   = 4,
    parameter int CW       = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [3:0]            number,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CW-1:0]         digit_count,
    output logic [3:0]            last_digit,
    output logic                  digit_strobe,
    output logic                  overflow
);

    localparam int                CNT_W      = $clog2(DEBOUNCE + 1);
    localparam int                DW         = 4 * DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CW-1:0]     COUNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         r_cand;
    logic [3:0]         w_cand_nxt;
    logic               w_pressed;
    logic               w_accept;

    logic [DW-1:0]      r_digits;
    logic [DW-1:0]      w_digits_nxt;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic [3:0]         r_last;
    logic [3:0]         w_last_nxt;
    logic               r_strobe;
    logic               w_strobe_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;

    // A code above 9 is indistinguishable from no key at all.
    assign w_pressed = valid && (number <= 4'd9);

    // State register: FSM state, debounce counter and candidate digit.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Next-state logic: press qualification, hold, and release qualification.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pressed) begin
                    w_cand_nxt  = number;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed || (number != r_cand)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt < CNT_LAST) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                // Key changes while held are ignored: no auto-repeat.
                if (!w_pressed) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = REL_WAIT;
                end
            end
            REL_WAIT: begin
                if (w_pressed) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: next values of the entry register; clear beats an accept.
    always_comb begin
        w_digits_nxt   = r_digits;
        w_count_nxt    = r_count;
        w_last_nxt     = r_last;
        w_strobe_nxt   = 1'b0;
        w_overflow_nxt = 1'b0;
        if (clear) begin
            w_digits_nxt = '0;
            w_count_nxt  = '0;
            w_last_nxt   = '0;
        end else if (w_accept) begin
            w_digits_nxt   = (r_digits << 4) | DW'(r_cand);
            w_last_nxt     = r_cand;
            w_count_nxt    = (r_count == COUNT_FULL) ? r_count : r_count + CW'(1);
            w_strobe_nxt   = 1'b1;
            w_overflow_nxt = (r_count == COUNT_FULL);
        end
    end

    // Entry register and pulses, registered so no input reaches an output combinationally.
    // NOTE: every register here is small control/data state, so all of it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits   <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_strobe   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_digits   <= w_digits_nxt;
            r_count    <= w_count_nxt;
            r_last     <= w_last_nxt;
            r_strobe   <= w_strobe_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign digits       = r_digits;
    assign digit_count  = r_count;
    assign last_digit   = r_last;
    assign digit_strobe = r_strobe;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry (DEBOUNCE=4, DIGITS=4): stimulus pushes the
// expected accept (edge number and outputs) into a queue; a negedge monitor
// compares strobe/overflow every cycle and pops on the expected edge.
module tb_keypad_entry;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [3:0]  number;
    logic        clear;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic [3:0]  last_digit;
    logic        digit_strobe;
    logic        overflow;

    keypad_entry #(.DEBOUNCE(4), .DIGITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .number       (number),
        .clear        (clear),
        .digits       (digits),
        .digit_count  (digit_count),
        .last_digit   (last_digit),
        .digit_strobe (digit_strobe),
        .overflow     (overflow)
    );

    typedef struct {
        int          e_cyc;
        logic [15:0] d;
        logic [2:0]  cnt;
        logic [3:0]  last;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // One sample: inputs change at the negedge and are taken at the next posedge.
    task automatic step(input logic v, input logic [3:0] n, input logic c);
        @(negedge clk);
        valid  = v;
        number = n;
        clear  = c;
    endtask

    // Called right after the step whose sample should cause the accept.
    task automatic push_exp(input logic [15:0] d, input logic [2:0] c, input logic [3:0] l, input logic o);
        exp_t e;
        e.e_cyc = cyc + 1;
        e.d     = d;
        e.cnt   = c;
        e.last  = l;
        e.ovf   = o;
        q.push_back(e);
    endtask

    // Clean key: accept on the 4th held sample.
    task automatic key(input logic [3:0] k, input int hold, input int rel,
                       input logic [15:0] d, input logic [2:0] c, input logic o);
        for (int i = 0; i < hold; i++) begin
            step(1'b1, k, 1'b0);
            if (i == 3) push_exp(d, c, k, o);
        end
        for (int i = 0; i < rel; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 4'd0, 1'b0);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic do_clear();
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        check("clear_digits", digits, 16'h0000);
    endtask

    // Monitor: strobe/overflow checked every cycle, fields checked on expected edges.
    always @(negedge clk) begin
        exp_t e;
        logic exp_s;
        logic exp_o;
        exp_s = 1'b0;
        exp_o = 1'b0;
        while (q.size() > 0 && q[0].e_cyc < cyc) void'(q.pop_front());
        if (q.size() > 0 && q[0].e_cyc == cyc) begin
            exp_s = 1'b1;
            exp_o = q[0].ovf;
        end
        check("digit_strobe", digit_strobe, exp_s);
        check("overflow", overflow, exp_o);
        if (exp_s) begin
            e = q.pop_front();
            check("acc_digits", digits, e.d);
            check("acc_count", digit_count, e.cnt);
            check("acc_last", last_digit, e.last);
        end
    end

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        number = 4'd0;
        clear  = 1'b0;
        #1;
        check("rst_digits", digits, 16'h0000);
        check("rst_count", digit_count, 3'd0);
        check("rst_last", last_digit, 4'd0);
        check("rst_strobe", digit_strobe, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-PRESS_WAIT with digits=0012, key 7 held through release.
        key(4'd1, 6, 6, 16'h0001, 3'd1, 1'b0);
        key(4'd2, 6, 6, 16'h0012, 3'd2, 1'b0);
        drain();
        check("pre_rst_digits", digits, 16'h0012);
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        #1 rst_n = 1'b0;
        number = 4'd7;
        #1;
        check("midrst_digits", digits, 16'h0000);
        check("midrst_count", digit_count, 3'd0);
        check("midrst_last", last_digit, 4'd0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd7, 1'b0);
            if (i == 2) push_exp(16'h0007, 3'd1, 4'd7, 1'b0);
        end
        repeat (2) step(1'b1, 4'd7, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        drain();

        // Clean presses 1,2,3.
        do_clear();
        key(4'd1, 6, 6, 16'h0001, 3'd1, 1'b0);
        key(4'd2, 6, 6, 16'h0012, 3'd2, 1'b0);
        key(4'd3, 6, 6, 16'h0123, 3'd3, 1'b0);
        drain();
        check("clean_digits", digits, 16'h0123);
        check("clean_count", digit_count, 3'd3);
        check("clean_last", last_digit, 4'd3);

        // Press bounce 1,1,0,1,1,1,1 then release bounce 0,0,1,0,0,0,0.
        do_clear();
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd5, 1'b0);
        push_exp(16'h0005, 3'd1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        // Number changes 5->8 in PRESS_WAIT: restart, 8 needs 4 further matches.
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd8, 1'b0);
        push_exp(16'h0058, 3'd2, 4'd8, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        drain();

        // Fill to four digits, then overflow on 9.
        do_clear();
        key(4'd1, 6, 6, 16'h0001, 3'd1, 1'b0);
        key(4'd2, 6, 6, 16'h0012, 3'd2, 1'b0);
        key(4'd3, 6, 6, 16'h0123, 3'd3, 1'b0);
        key(4'd4, 6, 6, 16'h1234, 3'd4, 1'b0);
        key(4'd9, 6, 6, 16'h2349, 3'd4, 1'b1);
        drain();
        check("ovf_digits", digits, 16'h2349);
        check("ovf_count", digit_count, 3'd4);

        // Clear on the accept edge of key 6: digit discarded, no re-accept while held.
        for (int i = 0; i < 3; i++) step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd6, 1'b1);
        step(1'b1, 4'd6, 1'b0);
        check("coll_digits", digits, 16'h0000);
        check("coll_count", digit_count, 3'd0);
        check("coll_last", last_digit, 4'd0);
        repeat (6) step(1'b1, 4'd6, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        key(4'd6, 6, 6, 16'h0006, 3'd1, 1'b0);
        drain();

        // Invalid code for 10 cycles, short 3-cycle press, then a clean key.
        repeat (10) step(1'b1, 4'hB, 1'b0);
        repeat (3) step(1'b1, 4'd4, 1'b0);
        repeat (6) step(1'b0, 4'd0, 1'b0);
        check("short_count", digit_count, 3'd1);
        repeat (10) step(1'b1, 4'hB, 1'b0);
        key(4'd2, 6, 6, 16'h0062, 3'd2, 1'b0);
        drain();
        check("final_digits", digits, 16'h0062);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Sequential stage directly downstream of the combinational keypad decoder. It consumes the decoder's `valid` and `number` outputs, debounces each key press and release, and shifts each accepted digit into a DIGITS-deep BCD entry register. It presents the entered value, a digit count and a one-cycle strobe to the control logic downstream.

## Interface
- `DEBOUNCE`, default 4: consecutive identical samples needed to accept a press or a release. Legal range is 2..255.
- `DIGITS`, default 4: depth of the BCD entry register in digits. Legal range is 1..8.
- `CW`, default $clog2(DIGITS+1): width of `digit_count`.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `valid`  input  1  key-present flag from the keypad decoder.
- `number`  input  4  decoded key value from the keypad decoder; 0..9 expected.
- `clear`  input  1  synchronous clear of the entry register.
- `digits`  output  4*DIGITS  BCD entry register; newest digit in [3:0].
- `digit_count`  output  CW  number of digits held, saturating at DIGITS.
- `last_digit`  output  4  most recently accepted digit.
- `digit_strobe`  output  1  one-cycle pulse per accepted digit.
- `overflow`  output  1  one-cycle pulse when an accepted digit pushes the oldest digit out.

## Operation
**Sampling**
- A sample is *pressed* when `valid`=1 and `number`≤9.
- `valid`=1 with `number`>9 is treated exactly as `valid`=0.
- The block does not synchronise its inputs.

**FSM states:** IDLE, PRESS_WAIT, HELD, REL_WAIT. An internal counter `cnt` of width ≥ log2(DEBOUNCE+1) and a 4-bit candidate register `cand` support the states.

**IDLE**
- On a pressed sample: `cand`←`number`, `cnt`←1, go to PRESS_WAIT.
- Otherwise stay in IDLE.

**PRESS_WAIT**
- Not pressed, or `number`≠`cand`: go to IDLE, `cnt`←0.
- Matching sample with `cnt`<DEBOUNCE-1: `cnt`++.
- Matching sample with `cnt`=DEBOUNCE-1: this is the DEBOUNCE-th consecutive match. Accept the digit and go to HELD.

**Accept**
- `digits`←{`digits`[4*DIGITS-5:0], `cand`}.
- `last_digit`←`cand`.
- `digit_count`←min(`digit_count`+1, DIGITS).
- `digit_strobe`←1.
- `overflow`←1 only if `digit_count` was already DIGITS.

**HELD**
- Changes of `number` are ignored, so there is no auto-repeat.
- Not pressed: `cnt`←1, go to REL_WAIT.

**REL_WAIT**
- Pressed sample: go to HELD.
- Otherwise `cnt`++.
- At the DEBOUNCE-th consecutive unpressed sample: go to IDLE.

**`clear`**
- Sets `digits`, `digit_count` and `last_digit` to 0 on the next edge.
- Has priority over an accept in the same cycle. That digit is discarded: no strobe, no overflow. The FSM still advances to HELD, so the held key is not re-accepted.
- `clear` never alters the FSM or `cnt`.

## Timing
- **Reset values (`rst_n`=0):**
  - FSM=IDLE, `cnt`=0, `cand`=0.
  - `digits`=0, `digit_count`=0, `last_digit`=0.
  - `digit_strobe`=0, `overflow`=0.
  - All take effect immediately, independent of `clk`.
- **Reset mid-operation:** a press in progress is abandoned. After `rst_n` rises, a key still held is treated as a new press and needs a full DEBOUNCE samples.
- **Outputs:** all are registered; there are no combinational input-to-output paths.
- **Press latency:** the first pressed sample is taken at edge E0. If samples at E0..E0+DEBOUNCE-1 all match, the accept updates on edge E0+DEBOUNCE-1. Outputs, including `digit_strobe`, are visible for the following cycle.
- **Pulse width:** `digit_strobe` and `overflow` are high for exactly one cycle. They are low in every other cycle.
- **Minimum cycle between digits:** DEBOUNCE pressed samples, then DEBOUNCE released samples, then DEBOUNCE pressed samples for the next key.
- **Bounce during a press:** a single unpressed or mismatching sample in PRESS_WAIT restarts qualification from IDLE. The next pressed sample counts as sample 1.
- **Bounce during a release:** a single pressed sample in REL_WAIT returns the FSM to HELD, with no new accept.
- **Register full:** `digit_count` holds at DIGITS. The oldest digit `digits`[4*DIGITS-1:4*DIGITS-4] is dropped with `overflow`=1.

## Test plan
All scenarios use DEBOUNCE=4 and DIGITS=4.
- **Reset:** assert `rst_n`=0 mid-PRESS_WAIT with `digits`=16'h0012 → all outputs 0 immediately. Hold key 7 through reset release → accept exactly 4 samples after release, `digits`=16'h0007, count=1.
- **Clean presses:** press 1, 2, 3 cleanly, each held 6 cycles and released 6 cycles → `digits`=16'h0123, count=3, `last_digit`=3, three strobes each 1 cycle wide, strobe 4 samples after each press starts.
- **Bounce:** key 5 with pattern 1,1,0,1,1,1,1 → one accept, strobe after the 7th sample. Release pattern 0,0,1,0,0,0,0 → no second accept. Number changing 5→8 during PRESS_WAIT → restart, 8 accepted after 4 further matches.
- **Overflow:** enter 1,2,3,4 → `digits`=16'h1234, count=4, no overflow. Enter 9 → `digits`=16'h2349, count=4, `overflow`=1 for one cycle together with the strobe.
- **`clear` collision:** assert `clear` on the accept edge of key 6 → `digits`=0, count=0, no strobe. Keep key held → no re-accept. Release, press 6 → `digits`=16'h0006.
- **Invalid code / short pulse:** `valid`=1 with `number`=4'hB for 10 cycles → nothing accepted, FSM stays IDLE. 3-cycle press of key 4 → no accept.
